// File: rtl/johnson_counter_ext.sv
`default_nettype none
// ============================================================================
// Module   : johnson_counter_ext
// Brief    : Parametrised twisted-ring counter with direction, load, self-
//            correction of lock-out states, index/phase decode and wrap pulse.
// Revision : 1.0 - initial release
// ============================================================================
module johnson_counter_ext #(
    parameter int WIDTH = 4,
    parameter int IW    = $clog2(2*WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               dir,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    output logic [WIDTH-1:0]   count,
    output logic [IW-1:0]      idx,
    output logic [2*WIDTH-1:0] phase,
    output logic               wrap,
    output logic               fault
);

    localparam logic [WIDTH-1:0]   c_one       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] c_phase_one = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]      c_last      = IW'(2*WIDTH-1);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_fault;
    logic             w_legal;
    logic             w_load_legal;
    logic [IW-1:0]    w_ones;
    logic [IW-1:0]    w_idx;

    // Legal = a run of ones touching the LSB, or its complement (run at MSB).
    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] nv;
        nv = ~v;
        return ((v & (v + c_one)) == '0) || ((nv & (nv + c_one)) == '0);
    endfunction

    assign w_legal      = is_legal(r_count);
    assign w_load_legal = is_legal(load_val);

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_ones = w_ones + IW'(r_count[i]);
        end
    end

    always_comb begin
        w_idx = '0;
        if (!w_legal) begin
            w_idx = '0;
        end else if (r_count[WIDTH-1]) begin
            w_idx = w_ones;
        end else if (w_ones != '0) begin
            w_idx = IW'(2*WIDTH - int'(w_ones));
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_fault <= 1'b0;
        end else if (load) begin
            r_count <= w_load_legal ? load_val : '0;
            r_wrap  <= 1'b0;
            r_fault <= !w_load_legal;
        end else if (!w_legal) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_fault <= 1'b1;
        end else if (en) begin
            if (dir) begin
                r_count <= {r_count[WIDTH-2:0], ~r_count[WIDTH-1]};
                r_wrap  <= (w_idx == '0);
            end else begin
                r_count <= {~r_count[0], r_count[WIDTH-1:1]};
                r_wrap  <= (w_idx == c_last);
            end
            r_fault <= 1'b0;
        end else begin
            r_wrap  <= 1'b0;
            r_fault <= 1'b0;
        end
    end

    assign count = r_count;
    assign idx   = w_idx;
    assign phase = c_phase_one << w_idx;
    assign wrap  = r_wrap;
    assign fault = r_fault;

endmodule
`default_nettype wire

// File: doc/johnson_counter_ext.md
# johnson_counter_ext

Parametrised Johnson (twisted-ring) counter with WIDTH-bit state, giving a 2*WIDTH-state sequence. Adds the following beyond a fixed 4-bit ring:
- bidirectional stepping, count enable, and parallel load with legality checking;
- self-correction of illegal (lock-out) states;
- binary index and one-hot phase decode, plus a wrap pulse.

It is used as a glitch-free multi-phase sequencer and timing generator in the counter library, and drives phase-select and strobe logic directly.

## Interface
- WIDTH, 4, ring width in bits; legal range WIDTH >= 2; sequence length 2*WIDTH.
- IW, $clog2(2*WIDTH), width of the index output (derived; not overridden by users).
- clk  input  1  clock; all state updates on the falling edge.
- reset  input  1  asynchronous, active-low reset; asserts immediately, releases synchronously to the next falling edge.
- en  input  1  step enable.
- dir  input  1  0 = forward step, 1 = reverse step.
- load  input  1  synchronous parallel load request.
- load_val  input  WIDTH  value presented with load.
- count  output  WIDTH  registered ring state.
- idx  output  IW  binary position of count in the forward sequence, 0..2*WIDTH-1; combinational decode of count.
- phase  output  2*WIDTH  one-hot of idx (phase[idx] = 1); combinational decode of count.
- wrap  output  1  registered one-cycle pulse on a sequence wrap.
- fault  output  1  registered one-cycle pulse when an illegal state is corrected or an illegal load is rejected.

## Operation
- Forward step: count <= {~count[0], count[WIDTH-1:1]}.
- Reverse step: count <= {count[WIDTH-2:0], ~count[WIDTH-1]}.
- Legal states are all zeros, all ones, or a single contiguous run of n ones anchored at the MSB or at the LSB. There are 2*WIDTH legal states; every other value is illegal.
- Index decode:
  - all zeros -> 0;
  - n ones anchored at the MSB (1 <= n <= WIDTH) -> n;
  - n ones anchored at the LSB (1 <= n <= WIDTH-1) -> 2*WIDTH-n.
- Index decode for WIDTH=4: 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7.
- Per-edge priority, highest first:
  1. reset asserted;
  2. load;
  3. illegal current state;
  4. en;
  5. hold.
- load, legal load_val: count <= load_val; wrap <= 0; fault <= 0. en and dir are ignored.
- load, illegal load_val: count <= 0; fault <= 1.
- No load, current count illegal: count <= 0 and fault <= 1, regardless of en.
- en=1, count legal: step in the direction given by dir.
  - wrap <= 1 if the step moves idx 2*WIDTH-1 -> 0 (forward) or 0 -> 2*WIDTH-1 (reverse); otherwise wrap <= 0.
- en=0: count holds; wrap <= 0; fault <= 0.
- When count is illegal, idx and phase output 0 and phase[0] respectively until the correction edge.
- dir may change on any cycle. It takes effect at the next enabled edge and causes no extra state.

## Timing
- Reset values: count = 0, idx = 0, phase = 1 (bit 0 set), wrap = 0, fault = 0. These appear without a clock edge.
- Reset asserted mid-sequence clears the counter immediately. The first step after release occurs on the first falling edge with reset high.
- Step latency: one falling edge from en=1 to the new count.
- idx and phase are valid in the same cycle as count (zero latency).
- wrap and fault are high for exactly one clock period after the edge that causes them.
- Load takes effect on the edge at which load is sampled high. Back-to-back loads are allowed.
- Recovery from any illegal state completes in exactly one edge. The counter never enters a lock-out cycle.

## Test plan
All scenarios use WIDTH=4.

- Reset: drive reset=0 between edges while count=1110 -> count=0000, phase=8'b00000001 immediately, before the next edge.
- Forward run: reset released, en=1, dir=0, 8 falling edges -> count 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000; idx 1..7 then 0; wrap=1 only after the 8th edge.
- Reverse run and direction change: start from 0000, en=1, dir=1 -> 0001 (idx 7, wrap=1), then 0011; set dir=0 -> 0001, then 0000 (wrap=1); en=0 for 3 edges -> count holds, wrap=0.
- Load: load=1, load_val=0111, en=1 -> count=0111, idx=5, fault=0; load_val=0101 -> count=0000, fault=1 for one cycle.
- Illegal-state recovery: force count=1010, then release -> idx=0 while illegal; on the next edge (en=0) count=0000 and fault=1; following edge fault=0.
- Parameter sweep: WIDTH=2 and WIDTH=7, free-running forward -> period 4 and 14 edges respectively; exactly one wrap per period; phase always one-hot.
